// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the request/rvalid bus. Every request
// is accepted (no grant). Each one gets exactly one in-order response after
// LATENCY cycles. Storage is byte-writable and is not cleared by reset.
module mem_responder #(
    parameter int unsigned MEM_W     = 32,
    parameter int unsigned MEM_SIZE  = 65536,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 mem_req_i,
    input  logic [31:0]          mem_addr_i,
    input  logic                 mem_we_i,
    input  logic [MEM_W/8-1:0]   mem_be_i,
    input  logic [MEM_W-1:0]     mem_wdata_i,
    output logic                 mem_rvalid_o,
    output logic                 mem_err_o,
    output logic [MEM_W-1:0]     mem_rdata_o
);

    localparam int unsigned BYTES  = MEM_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int unsigned DEPTH  = MEM_SIZE / BYTES;
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SIZE_L = 33'(MEM_SIZE);

    logic [MEM_W-1:0] mem [DEPTH];

    logic [32:0]      diff;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic             acc_req;

    logic             vld_p  [LATENCY];
    logic             err_p  [LATENCY];
    logic [MEM_W-1:0] data_p [LATENCY];

    // Address decode: the 33rd bit of the subtraction is the borrow, set when
    // the address lies below BASE_ADDR and the 32-bit offset has wrapped.
    always_comb begin
        diff     = {1'b0, mem_addr_i} - {1'b0, BASE_ADDR};
        in_range = !diff[32] && ({1'b0, diff[31:0]} < SIZE_L);
        word_idx = diff[OFF_W +: IDX_W];
        acc_req  = mem_req_i && rst_ni;
    end

    // Byte-enabled storage write; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (acc_req && mem_we_i && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (mem_be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= mem_wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captures the response at the acceptance edge,
    // then the response shifts one stage per cycle toward the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_p[i]  <= 1'b0;
                err_p[i]  <= 1'b0;
                data_p[i] <= '0;
            end
        end else begin
            // ---- stage p0: capture (reads see all writes of earlier cycles)
            vld_p[0]  <= acc_req;
            err_p[0]  <= acc_req && !in_range;
            data_p[0] <= (acc_req && !mem_we_i && in_range) ? mem[word_idx] : '0;
            // ---- stages p1..p(LATENCY-1): plain delay
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i]  <= vld_p[i-1];
                err_p[i]  <= err_p[i-1];
                data_p[i] <= data_p[i-1];
            end
        end
    end

    // ---- output: straight from the last stage flops
    assign mem_rvalid_o = vld_p[LATENCY-1];
    assign mem_err_o    = err_p[LATENCY-1];
    assign mem_rdata_o  = data_p[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scenarios followed by random traffic, all
// checked against a byte-level memory model and a queue of timed responses.
module tb_mem_responder;

    localparam int unsigned MEM_W    = 32;
    localparam int unsigned MEM_SIZE = 65536;
    localparam logic [31:0] BASE     = 32'h0000_0000;
    localparam int unsigned LAT      = 2;
    localparam int unsigned BYTES    = MEM_W / 8;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              mem_req_i = 1'b0;
    logic [31:0]       mem_addr_i = '0;
    logic              mem_we_i = 1'b0;
    logic [BYTES-1:0]  mem_be_i = '0;
    logic [MEM_W-1:0]  mem_wdata_i = '0;
    logic              mem_rvalid_o;
    logic              mem_err_o;
    logic [MEM_W-1:0]  mem_rdata_o;

    mem_responder #(
        .MEM_W(MEM_W), .MEM_SIZE(MEM_SIZE), .BASE_ADDR(BASE), .LATENCY(LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .mem_req_i(mem_req_i),
        .mem_addr_i(mem_addr_i), .mem_we_i(mem_we_i), .mem_be_i(mem_be_i),
        .mem_wdata_i(mem_wdata_i), .mem_rvalid_o(mem_rvalid_o),
        .mem_err_o(mem_err_o), .mem_rdata_o(mem_rdata_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned      due;
        bit               err;
        logic [MEM_W-1:0] data;
        bit               known;
    } resp_t;

    resp_t            exp_q[$];
    logic [7:0]       model_mem [int unsigned];
    int unsigned      edge_n = 0;
    int               n_checks = 0;
    int               n_errs = 0;
    logic [MEM_W-1:0] last_rdata = '0;
    logic             last_err = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Reference model: byte-addressed memory, response decided at issue time.
    task automatic model_access(input bit we, input logic [31:0] addr,
                                input logic [BYTES-1:0] be,
                                input logic [MEM_W-1:0] wdata, output resp_t r);
        longint off;
        longint base;
        bit     in_r;
        off  = longint'(addr) - longint'(BASE);
        in_r = (off >= 0) && (off < longint'(MEM_SIZE));
        base = (off / BYTES) * BYTES;
        r.err   = !in_r;
        r.data  = '0;
        r.known = 1'b1;
        r.due   = 0;
        if (in_r && we) begin
            for (int b = 0; b < BYTES; b++)
                if (be[b]) model_mem[int'(base) + b] = wdata[8*b +: 8];
        end else if (in_r) begin
            for (int b = 0; b < BYTES; b++) begin
                if (model_mem.exists(int'(base) + b)) r.data[8*b +: 8] = model_mem[int'(base) + b];
                else r.known = 1'b0;
            end
        end
    endtask

    task automatic check_outputs(input int unsigned last_edge);
        resp_t r;
        if (exp_q.size() > 0 && exp_q[0].due == last_edge) begin
            r = exp_q.pop_front();
            check("rvalid", 64'(mem_rvalid_o), 64'(1));
            check("err", 64'(mem_err_o), 64'(r.err));
            if (r.known) check("rdata", 64'(mem_rdata_o), 64'(r.data));
            last_rdata = mem_rdata_o;
            last_err   = mem_err_o;
        end else begin
            check("idle_rvalid", 64'(mem_rvalid_o), 64'(0));
            check("idle_err", 64'(mem_err_o), 64'(0));
            check("idle_rdata", 64'(mem_rdata_o), 64'(0));
        end
    endtask

    // One bus cycle: drive, let the edge happen, check at the falling edge.
    task automatic cycle(input bit req, input bit we, input logic [31:0] addr,
                         input logic [BYTES-1:0] be, input logic [MEM_W-1:0] wdata);
        resp_t r;
        mem_req_i   = req;
        mem_we_i    = we;
        mem_addr_i  = addr;
        mem_be_i    = be;
        mem_wdata_i = wdata;
        if (req && rst_ni) begin
            model_access(we, addr, be, wdata, r);
            r.due = edge_n + LAT - 1;
            exp_q.push_back(r);
        end
        @(posedge clk_i);
        edge_n++;
        @(negedge clk_i);
        check_outputs(edge_n - 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        bit               rq;
        bit               w;
        int unsigned      sel;
        logic [31:0]      a;

        // Reset state
        #2;
        check("rst_rvalid", 64'(mem_rvalid_o), 64'(0));
        check("rst_err", 64'(mem_err_o), 64'(0));
        check("rst_rdata", 64'(mem_rdata_o), 64'(0));
        idle(2);
        rst_ni = 1'b1;

        // Write then read
        cycle(1, 1, 32'h100, 4'b1111, 32'hDEADBEEF);
        cycle(1, 0, 32'h100, 4'b0000, 32'h0);
        idle(2);
        check("wr_then_rd", 64'(last_rdata), 64'(32'hDEADBEEF));

        // Partial write
        cycle(1, 1, 32'h100, 4'b0101, 32'h11223344);
        cycle(1, 0, 32'h100, 4'b0000, 32'h0);
        idle(2);
        check("partial_wr", 64'(last_rdata), 64'(32'hDE22BE44));

        // Unaligned address, be=0 no-op write
        cycle(1, 1, 32'h103, 4'b0000, 32'hAAAAAAAA);
        cycle(1, 0, 32'h102, 4'b0000, 32'h0);
        idle(2);
        check("be0_noop", 64'(last_rdata), 64'(32'hDE22BE44));

        // Back-to-back: preload then 8 consecutive reads
        for (int i = 0; i < 8; i++) cycle(1, 1, 32'(4*i), 4'b1111, 32'(4*i));
        idle(2);
        for (int i = 0; i < 8; i++) cycle(1, 0, 32'(4*i), 4'b0000, 32'h0);
        idle(3);
        check("b2b_last", 64'(last_rdata), 64'(32'h1C));

        // Range boundary
        cycle(1, 1, 32'hFFFC, 4'b1111, 32'h5A5A0FFC);
        cycle(1, 0, 32'hFFFC, 4'b0000, 32'h0);
        idle(2);
        check("edge_in_err", 64'(last_err), 64'(0));
        check("edge_in_data", 64'(last_rdata), 64'(32'h5A5A0FFC));
        cycle(1, 1, 32'h10000, 4'b1111, 32'hFFFFFFFF);
        cycle(1, 0, 32'h10000, 4'b0000, 32'h0);
        idle(2);
        check("oor_err", 64'(last_err), 64'(1));
        check("oor_rdata", 64'(last_rdata), 64'(0));
        cycle(1, 0, 32'h0, 4'b0000, 32'h0);
        idle(2);
        check("after_oor", 64'(last_err), 64'(0));

        // Reset mid-flight: second read's edge is where the first response
        // would appear; reset lands just after it.
        cycle(1, 0, 32'h100, 4'b0000, 32'h0);
        mem_addr_i = 32'h104;
        @(posedge clk_i);
        edge_n++;
        #1 rst_ni = 1'b0;
        exp_q.delete();
        #1;
        check("arst_rvalid", 64'(mem_rvalid_o), 64'(0));
        check("arst_err", 64'(mem_err_o), 64'(0));
        check("arst_rdata", 64'(mem_rdata_o), 64'(0));
        @(negedge clk_i);
        cycle(1, 1, 32'h100, 4'b1111, 32'hBAD0BAD0);
        cycle(1, 0, 32'h100, 4'b0000, 32'h0);
        rst_ni = 1'b1;
        idle(3);
        cycle(1, 0, 32'h100, 4'b0000, 32'h0);
        idle(2);
        check("retained", 64'(last_rdata), 64'(32'hDE22BE44));

        // Random traffic over a preloaded window plus out-of-range addresses
        for (int i = 0; i < 64; i++) cycle(1, 1, 32'h200 + 32'(4*i), 4'b1111, $urandom());
        for (int i = 0; i < 400; i++) begin
            rq  = ($urandom_range(0, 9) < 8);
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 8)       a = 32'h200 + 32'($urandom_range(0, 255));
            else if (sel == 8) a = 32'h10000 + 32'($urandom_range(0, 4095));
            else               a = $urandom() | 32'h8000_0000;
            cycle(rq, w, a, 4'($urandom_range(0, 15)), $urandom());
        end
        idle(LAT + 1);
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Synchronous memory responder: the memory-side end of the SoC's single-port request/rvalid bus. The CPU/coprocessor memory arbiter drives this bus as initiator.
- Accepts one request per cycle with no grant (implicit always-ready).
- Returns exactly one rvalid response per accepted request, reads and writes alike, in order, after a fixed pipelined latency.
- Used as the on-chip RAM in the SoC top and as the memory model in the core testbench.

Parameters:
- MEM_W, 32, data bus width in bits; multiple of 32.
- MEM_SIZE, 65536, memory size in bytes; power of two; multiple of MEM_W/8.
- BASE_ADDR, 32'h00000000, byte address of word 0; aligned to MEM_SIZE.
- LATENCY, 2, cycles from request to response; legal range 1..8.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- mem_req_i  input  1  request valid; sampled every rising edge, no grant.
- mem_addr_i  input  32  byte address; low log2(MEM_W/8) bits ignored.
- mem_we_i  input  1  1 = write, 0 = read.
- mem_be_i  input  MEM_W/8  byte enables, writes only.
- mem_wdata_i  input  MEM_W  write data.
- mem_rvalid_o  output  1  response valid; one cycle per accepted request.
- mem_err_o  output  1  response error (address out of range); qualified by rvalid.
- mem_rdata_o  output  MEM_W  read data; full aligned word.

Behaviour:
- Reset is asynchronous, clock is clk_i.
- Reset values: mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0. All pipeline valid bits cleared.
- Storage array is not reset; contents persist across reset.
- Acceptance: every rising edge with mem_req_i=1 is one accepted request. No backpressure and no request dropping.
- Address decode: offset = mem_addr_i - BASE_ADDR (32-bit unsigned wrap). Word index = offset >> log2(MEM_W/8).
  - in_range = (mem_addr_i >= BASE_ADDR) and (offset < MEM_SIZE).
- Write, in range: at the acceptance edge, each byte i with mem_be_i[i]=1 takes mem_wdata_i[8i+7:8i]. Other bytes are unchanged. be=0 is a legal no-op write that still gets a response.
- Read, in range: data captured at the acceptance edge. It reflects all writes accepted in earlier cycles, so read-after-write on back-to-back cycles returns the new data.
- Out of range: no storage access. Response has err=1 and rdata=0, for reads and writes.
- Write response: rvalid=1, err as decoded, rdata=0.
- Latency: request accepted at edge t produces mem_rvalid_o=1 during the cycle following edge t+LATENCY-1. With LATENCY=1, the response is visible in the cycle right after the request cycle.
- Pipeline: LATENCY-deep shift register of {valid, err, data}, advanced every cycle.
  - Fully pipelined: N consecutive requests produce N consecutive rvalid cycles, in request order.
  - Up to LATENCY responses are in flight.
- Outputs are driven directly from the final pipeline stage flops, with no combinational path from inputs. mem_rdata_o and mem_err_o are 0 whenever mem_rvalid_o=0.
- Reset mid-operation: all in-flight responses are discarded. Outputs go to 0 asynchronously. No stale rvalid after reset release.
  - Writes accepted before reset assertion remain in storage.
- Requests while rst_ni=0 are ignored.
- Address wrap: a request whose offset computation wraps (addr < BASE_ADDR) is out of range and gets err=1.

Test Plan:
All scenarios use LATENCY=2, BASE_ADDR=0, MEM_SIZE=0x10000, MEM_W=32; request cycles are numbered from 0.
- Write then read: cycle 0 write 0xDEADBEEF to 0x100, be=4'b1111; cycle 1 read 0x100 -> cycle 2 rvalid=1, err=0, rdata=0; cycle 3 rvalid=1, rdata=0xDEADBEEF.
- Partial write: after the above, write 0x11223344 to 0x100 with be=4'b0101, then read 0x100 -> rdata=0xDE22BE44.
- Unaligned and be=0: write 0xAAAAAAAA to 0x103 with be=4'b0000 (response rvalid=1, err=0); then read 0x102 -> rdata=0xDE22BE44, unchanged.
- Range boundary: read 0xFFFC -> err=0. Write 0xFFFFFFFF to 0x10000, then read 0x10000 -> both responses err=1, rdata=0. A following read of 0x0 is unaffected.
- Back-to-back: preload words 0x0..0x1C with their addresses; issue 8 reads in cycles 0..7 -> rvalid=1 in cycles 2..9 with rdata 0x0,0x4,...,0x1C in order; rvalid=0 in cycle 10.
- Reset mid-flight: reads in cycles 0 and 1, rst_ni=0 in cycle 2 -> rvalid=0 immediately and stays 0 after release. A fresh read of 0x100 after release returns 0xDE22BE44, since storage is retained.
